// File: rtl/mov_str_unit.sv
// MOV/STR execution unit: register write-back for MOV, req/ack store for STR.
// Optional byte store (STRB) is compiled in with `define MOV_STR_BYTE_EN.
module mov_str_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int REG_AW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          op,
    input  logic [DATA_W-1:0]   src_data,
    input  logic [REG_AW-1:0]   dst_reg,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   offset,
    output logic                wb_en,
    output logic [REG_AW-1:0]   wb_reg,
    output logic [DATA_W-1:0]   wb_data,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    output logic                done,
    output logic                err
);

    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REQ,
        ERR
    } state_t;

    state_t state, nxt;

    logic              accept;
    logic [ADDR_W-1:0] ea;
    logic              is_mov;
    logic              is_str;
    logic              is_strb;
    logic              is_store;
    logic [DATA_W-1:0] st_wdata;
    logic [NB-1:0]     st_be;

    assign accept = in_valid & in_ready;
    // Carry out of the address add is discarded: addresses wrap.
    assign ea     = base_addr + offset;
    assign is_mov = (op == 2'b00);
    assign is_str = (op == 2'b01);

`ifdef MOV_STR_BYTE_EN
    logic [ADDR_W-1:0] lane;

    assign is_strb = (op == 2'b10);
    assign lane    = ea % ADDR_W'(NB);

    always_comb begin
        st_wdata = src_data;
        st_be    = '1;
        if (is_strb) begin
            st_wdata = {NB{src_data[7:0]}};
            for (int i = 0; i < NB; i++) begin
                st_be[i] = (lane == ADDR_W'(i));
            end
        end
    end
`else
    assign is_strb  = 1'b0;
    assign st_wdata = src_data;
    assign st_be    = '1;
`endif

    assign is_store = is_str | is_strb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        in_ready = 1'b0;
        wb_en    = 1'b0;
        mem_req  = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    unique case (1'b1)
                        is_mov:   nxt = WB;
                        is_store: nxt = REQ;
                        default:  nxt = ERR;
                    endcase
                end
            end
            WB: begin
                wb_en = 1'b1;
                done  = 1'b1;
                nxt   = IDLE;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    done = 1'b1;
                    nxt  = IDLE;
                end
            end
            ERR: begin
                err = 1'b1;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Data outputs only change on the accept of the matching op class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_reg    <= '0;
            wb_data   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (accept) begin
            if (is_mov) begin
                wb_reg  <= dst_reg;
                wb_data <= src_data;
            end
            if (is_store) begin
                mem_addr  <= ea;
                mem_wdata <= st_wdata;
                mem_be    <= st_be;
            end
        end
    end

endmodule

// File: tb/tb_mov_str_unit.sv
// Bench for mov_str_unit: vector table plus scoreboard queue.
// Byte-store expectations follow `define MOV_STR_BYTE_EN.
module tb_mov_str_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] src_data;
    logic [3:0]  dst_reg;
    logic [15:0] base_addr;
    logic [15:0] offset;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        err;

    mov_str_unit #(
        .DATA_W(32),
        .ADDR_W(16),
        .REG_AW(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .src_data (src_data),
        .dst_reg  (dst_reg),
        .base_addr(base_addr),
        .offset   (offset),
        .wb_en    (wb_en),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_ack  (mem_ack),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = write-back, 1 = store, 2 = illegal op
    typedef struct {
        logic [1:0]  op;
        logic [3:0]  dst;
        logic [31:0] src;
        logic [15:0] base;
        logic [15:0] off;
        int          dly;
        int          kind;
        logic [3:0]  ereg;
        logic [31:0] edata;
        logic [15:0] eaddr;
        logic [3:0]  ebe;
    } vec_t;

    typedef struct {
        int          kind;
        int          cyc;
        logic [3:0]  ereg;
        logic [31:0] edata;
        logic [15:0] eaddr;
        logic [3:0]  ebe;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vt[12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every done/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_en && mem_req) begin
                n_cmp++;
                n_err++;
                $display("FAIL excl_wb_mem: wb_en and mem_req both 1");
            end
            if (done || err) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: done=%b err=%b",
                             done, err);
                end else begin
                    me = sb.pop_front();
                    chk("latency", cyc, me.cyc);
                    chk("err", err, me.kind == 2);
                    chk("done", done, me.kind != 2);
                    chk("wb_en", wb_en, me.kind == 0);
                    chk("mem_req", mem_req, me.kind == 1);
                    if (me.kind == 0) begin
                        chk("wb_reg", wb_reg, me.ereg);
                        chk("wb_data", wb_data, me.edata);
                    end
                    if (me.kind == 1) begin
                        chk("mem_addr", mem_addr, me.eaddr);
                        chk("mem_be", mem_be, me.ebe);
                        chk("mem_wdata", mem_wdata, me.edata);
                    end
                end
            end
        end
    end

    task automatic run(input vec_t v);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", in_ready, 1);
        in_valid  = 1'b1;
        op        = v.op;
        dst_reg   = v.dst;
        src_data  = v.src;
        base_addr = v.base;
        offset    = v.off;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        op        = 2'($urandom);
        dst_reg   = 4'($urandom);
        src_data  = $urandom;
        base_addr = 16'($urandom);
        offset    = 16'($urandom);
        e.kind  = v.kind;
        e.cyc   = cyc + ((v.kind == 1) ? v.dly : 0);
        e.ereg  = v.ereg;
        e.edata = v.edata;
        e.eaddr = v.eaddr;
        e.ebe   = v.ebe;
        sb.push_back(e);
        if (v.kind == 1) begin
            mem_ack = (v.dly == 0);
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk);
                chk("req_hold", mem_req, 1);
                chk("addr_hold", mem_addr, v.eaddr);
                chk("be_hold", mem_be, v.ebe);
                chk("wdata_hold", mem_wdata, v.edata);
                @(posedge clk);
                #1;
                if (i == v.dly - 1) mem_ack = 1'b1;
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            @(negedge clk);
            chk("req_drop", mem_req, 0);
        end else begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("ready_n2", in_ready, 1);
            chk("wb_single", wb_en, 0);
            chk("no_req", mem_req, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 2'b00;
        src_data  = '0;
        dst_reg   = '0;
        base_addr = '0;
        offset    = '0;
        mem_ack   = 1'b0;

        vt[0]  = '{2'b00, 4'd5, 32'hDEADBEEF, 16'h0, 16'h0, 0,
                   0, 4'd5, 32'hDEADBEEF, 16'h0, 4'h0};
        vt[1]  = '{2'b01, 4'd0, 32'h12345678, 16'h1000, 16'h0024, 3,
                   1, 4'd0, 32'h12345678, 16'h1024, 4'hF};
        vt[2]  = '{2'b01, 4'd0, 32'hA5A5C3C3, 16'hFFFC, 16'h0008, 0,
                   1, 4'd0, 32'hA5A5C3C3, 16'h0004, 4'hF};
        vt[3]  = '{2'b11, 4'd3, 32'h11111111, 16'h0, 16'h0, 0,
                   2, 4'd0, 32'h0, 16'h0, 4'h0};
`ifdef MOV_STR_BYTE_EN
        vt[4]  = '{2'b10, 4'd0, 32'h000000AB, 16'h0100, 16'h0002, 0,
                   1, 4'd0, 32'hABABABAB, 16'h0102, 4'b0100};
        vt[5]  = '{2'b10, 4'd0, 32'h123456CD, 16'h00FF, 16'h0004, 1,
                   1, 4'd0, 32'hCDCDCDCD, 16'h0103, 4'b1000};
`else
        vt[4]  = '{2'b10, 4'd0, 32'h000000AB, 16'h0100, 16'h0002, 0,
                   2, 4'd0, 32'h0, 16'h0, 4'h0};
        vt[5]  = '{2'b10, 4'd0, 32'h123456CD, 16'h00FF, 16'h0004, 1,
                   2, 4'd0, 32'h0, 16'h0, 4'h0};
`endif
        vt[6]  = '{2'b00, 4'd15, 32'h00000000, 16'h0, 16'h0, 0,
                   0, 4'd15, 32'h00000000, 16'h0, 4'h0};
        vt[7]  = '{2'b00, 4'd0, 32'hFFFFFFFF, 16'h0, 16'h0, 0,
                   0, 4'd0, 32'hFFFFFFFF, 16'h0, 4'h0};
        vt[8]  = '{2'b01, 4'd0, 32'hCAFEF00D, 16'hFFFF, 16'h0001, 1,
                   1, 4'd0, 32'hCAFEF00D, 16'h0000, 4'hF};
        vt[9]  = '{2'b01, 4'd0, 32'h00000000, 16'h0000, 16'h0000, 2,
                   1, 4'd0, 32'h00000000, 16'h0000, 4'hF};
        vt[10] = '{2'b11, 4'd9, 32'h22222222, 16'h1234, 16'h1, 0,
                   2, 4'd0, 32'h0, 16'h0, 4'h0};
        vt[11] = '{2'b00, 4'd10, 32'h0BADC0DE, 16'h0, 16'h0, 0,
                   0, 4'd10, 32'h0BADC0DE, 16'h0, 4'h0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run(vt[i]);
        end

        // ack while idle or during MOV must be ignored
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        run(vt[7]);
        mem_ack = 1'b0;

        // reset in the middle of a stalled store
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 2'b01;
        src_data  = 32'h55AA55AA;
        base_addr = 16'h2000;
        offset    = 16'h0010;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_req", mem_req, 1);
        chk("mid_addr", mem_addr, 16'h2010);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_ready", in_ready, 1);
        run(vt[0]);
        run(vt[2]);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule
